// File: rtl/telemetry_frame_tx.sv
// 8N1 serial transmitter for the outbound telemetry frame:
// "abc" header, word_a and word_b MSB-first, then an additive checksum byte.
module telemetry_frame_tx #(
  parameter int ClkFrequency = 50000000,
  parameter int Baud         = 9600
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        send,
  input  logic [15:0] word_a,
  input  logic [15:0] word_b,
  output logic        busy,
  output logic        done,
  output logic        uart_tx,
  output logic [1:0]  state_o
);

  localparam int DIV = ClkFrequency / Baud;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] BAUD_ONE  = CW'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // Handshake: a request is taken when send=1 at a rising edge with busy=0;
  // send while busy=1 is dropped, there is no queueing.

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [2:0]    byte_idx_q, byte_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [15:0]   word_a_q, word_a_d;
  logic [15:0]   word_b_q, word_b_d;
  logic          tx_q, tx_d;
  logic          done_q, done_d;

  logic          bit_end;
  logic [2:0]    nxt_idx;
  logic [7:0]    checksum;
  logic [7:0]    next_byte;

  assign bit_end  = (baud_cnt_q == BAUD_LAST);
  assign nxt_idx  = byte_idx_q + 3'd1;
  assign checksum = word_a_q[15:8] + word_a_q[7:0] + word_b_q[15:8] + word_b_q[7:0];

  always_comb begin
    next_byte = 8'h61;
    case (nxt_idx)
      3'd1:    next_byte = 8'h62;
      3'd2:    next_byte = 8'h63;
      3'd3:    next_byte = word_a_q[15:8];
      3'd4:    next_byte = word_a_q[7:0];
      3'd5:    next_byte = word_b_q[15:8];
      3'd6:    next_byte = word_b_q[7:0];
      3'd7:    next_byte = checksum;
      default: next_byte = 8'h61;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    word_a_d   = word_a_q;
    word_b_d   = word_b_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (send) begin
          state_d    = S_START;
          baud_cnt_d = '0;
          byte_idx_d = 3'd0;
          shift_d    = 8'h61;
          word_a_d   = word_a;
          word_b_d   = word_b;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d    = S_DATA;
          baud_cnt_d = '0;
          bit_idx_d  = 3'd0;
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_ONE;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          shift_d    = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) state_d = S_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_ONE;
        end
      end
      default: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          if (byte_idx_q != 3'd7) begin
            byte_idx_d = nxt_idx;
            shift_d    = next_byte;
            state_d    = S_START;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_ONE;
        end
      end
    endcase
  end

  // Line level is derived from the next state so the pin register changes
  // exactly on bit boundaries.
  always_comb begin
    tx_d = 1'b1;
    if (state_d == S_START)     tx_d = 1'b0;
    else if (state_d == S_DATA) tx_d = shift_d[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= 3'd0;
      byte_idx_q <= 3'd0;
      shift_q    <= 8'h00;
      word_a_q   <= 16'h0000;
      word_b_q   <= 16'h0000;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      word_a_q   <= word_a_d;
      word_b_q   <= word_b_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign uart_tx = tx_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_telemetry_frame_tx.sv
// Bench for telemetry_frame_tx: a UART line monitor pops expected bytes from
// a queue filled when each request is driven; tasks check timing inline.
module tb_telemetry_frame_tx;

  localparam int DIV = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        send;
  logic [15:0] word_a;
  logic [15:0] word_b;
  logic        busy;
  logic        done;
  logic        uart_tx;
  logic [1:0]  state;

  logic        rst2_n;
  logic        send2;
  logic        busy2;
  logic        done2;
  logic        tx2;
  logic [1:0]  state2;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  telemetry_frame_tx #(.ClkFrequency(1000), .Baud(100)) dut (
    .clk(clk), .rst_n(rst_n), .send(send), .word_a(word_a), .word_b(word_b),
    .busy(busy), .done(done), .uart_tx(uart_tx), .state_o(state)
  );

  telemetry_frame_tx dut_dflt (
    .clk(clk), .rst_n(rst2_n), .send(send2), .word_a(16'hA55A), .word_b(16'h0FF0),
    .busy(busy2), .done(done2), .uart_tx(tx2), .state_o(state2)
  );

  // UART monitor: samples mid-bit, aborts its byte on reset
  initial begin : monitor
    int   t;
    int   k;
    logic active;
    logic [7:0] rx;
    logic [7:0] exp;
    active = 1'b0;
    t = 0;
    rx = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        active = 1'b0;
      end else if (!active) begin
        if (uart_tx === 1'b0) begin
          active = 1'b1;
          t = 0;
        end
      end else begin
        t++;
        if (t % DIV == DIV / 2) begin
          k = t / DIV;
          if (k == 0) begin
            checks++;
            if (uart_tx !== 1'b0) begin
              errors++;
              $display("FAIL start_bit got %b want 0", uart_tx);
            end
          end else if (k <= 8) begin
            rx[k-1] = uart_tx;
          end else begin
            checks++;
            if (uart_tx !== 1'b1) begin
              errors++;
              $display("FAIL stop_bit got %b want 1", uart_tx);
            end
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL unexpected_byte got %02h want none", rx);
            end else begin
              exp = exp_q.pop_front();
              if (rx !== exp) begin
                errors++;
                $display("FAIL frame_byte got %02h want %02h", rx, exp);
              end
            end
            active = 1'b0;
          end
        end
      end
    end
  end

  task automatic push_frame(input logic [15:0] a, input logic [15:0] b);
    logic [7:0] cs;
    cs = a[15:8] + a[7:0] + b[15:8] + b[7:0];
    exp_q.push_back(8'h61);
    exp_q.push_back(8'h62);
    exp_q.push_back(8'h63);
    exp_q.push_back(a[15:8]);
    exp_q.push_back(a[7:0]);
    exp_q.push_back(b[15:8]);
    exp_q.push_back(b[7:0]);
    exp_q.push_back(cs);
  endtask

  // Returns just after the accepting edge E0.
  task automatic send_pulse(input logic [15:0] a, input logic [15:0] b);
    @(posedge clk);
    #1;
    word_a = a;
    word_b = b;
    send   = 1'b1;
    push_frame(a, b);
    @(posedge clk);
    #1;
    send = 1'b0;
  endtask

  task automatic measure(input int window, output int busy_n, output int done_k,
                         output int done_n);
    busy_n = 0;
    done_k = -1;
    done_n = 0;
    for (int k = 1; k <= window; k++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1) begin
        done_n++;
        if (done_n == 1) done_k = k;
      end
    end
  endtask

  task automatic check_frame(input string name, input int busy_n, input int done_k,
                             input int done_n);
    checks++;
    if (busy_n != 80 * DIV) begin
      errors++;
      $display("FAIL %s_busy_len got %0d want %0d", name, busy_n, 80 * DIV);
    end
    checks++;
    if (done_k != 80 * DIV + 1) begin
      errors++;
      $display("FAIL %s_done_time got %0d want %0d", name, done_k, 80 * DIV + 1);
    end
    checks++;
    if (done_n != 1) begin
      errors++;
      $display("FAIL %s_done_count got %0d want 1", name, done_n);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_bytes_left got %0d want 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    rst2_n = 1'b0;
    send   = 1'b1;
    send2  = 1'b0;
    word_a = 16'h1111;
    word_b = 16'h2222;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({uart_tx, busy, done, state} !== 5'b10000) begin
        errors++;
        $display("FAIL reset_hold got tx/busy/done/state %b%b%b%02b want 10000",
                 uart_tx, busy, done, state);
      end
    end
    #2;
    rst_n  = 1'b1;
    rst2_n = 1'b1;
    send   = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({uart_tx, busy, done} !== 3'b100) begin
        errors++;
        $display("FAIL reset_release got tx/busy/done %b%b%b want 100", uart_tx, busy, done);
      end
    end
    checks++;
    if ({tx2, busy2, state2} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_dflt got tx/busy/state %b%b%02b want 1000", tx2, busy2, state2);
    end
  endtask

  task automatic test_basic_frame();
    int bn, dk, dn;
    send_pulse(16'h01F4, 16'h0300);
    measure(820, bn, dk, dn);
    check_frame("basic", bn, dk, dn);
  endtask

  task automatic test_checksum();
    int bn, dk, dn;
    send_pulse(16'hFFFF, 16'hFF01);
    measure(820, bn, dk, dn);
    check_frame("cs_wrap", bn, dk, dn);
    for (int i = 0; i < 2; i++) begin
      send_pulse(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
      measure(820, bn, dk, dn);
      check_frame("cs_rand", bn, dk, dn);
    end
  endtask

  task automatic test_busy_latch();
    int bn, dk, dn;
    send_pulse(16'h0A0B, 16'h0C0D);
    bn = 0;
    dn = 0;
    dk = -1;
    for (int k = 1; k <= 900; k++) begin
      @(negedge clk);
      if (k == 20) word_a = 16'h1234;
      if (k == 50) begin
        word_a = 16'h5566;
        word_b = 16'h7788;
        send   = 1'b1;
      end
      if (k == 51) send = 1'b0;
      if (busy === 1'b1) bn++;
      if (done === 1'b1) begin
        dn++;
        if (dn == 1) dk = k;
      end
    end
    check_frame("latch", bn, dk, dn);
  endtask

  task automatic test_back_to_back();
    int d1, d2, dn, gap_tx, post_tx;
    d1 = -1;
    d2 = -1;
    dn = 0;
    gap_tx = -1;
    post_tx = -1;
    @(posedge clk);
    #1;
    word_a = 16'hBEEF;
    word_b = 16'h4321;
    send   = 1'b1;
    push_frame(16'hBEEF, 16'h4321);
    push_frame(16'hBEEF, 16'h4321);
    @(posedge clk);
    #1;
    for (int k = 1; k <= 1700; k++) begin
      @(negedge clk);
      if (k == d1 + 1) begin
        post_tx = int'(uart_tx);
        send = 1'b0;
      end
      if (done === 1'b1) begin
        dn++;
        if (dn == 1) begin
          d1 = k;
          gap_tx = int'(uart_tx);
        end else if (dn == 2) begin
          d2 = k;
        end
      end
    end
    send = 1'b0;
    checks++;
    if (dn != 2) begin
      errors++;
      $display("FAIL b2b_done_count got %0d want 2", dn);
    end
    checks++;
    if (d2 - d1 != 80 * DIV + 1) begin
      errors++;
      $display("FAIL b2b_done_spacing got %0d want %0d", d2 - d1, 80 * DIV + 1);
    end
    checks++;
    if (gap_tx != 1 || post_tx != 0) begin
      errors++;
      $display("FAIL b2b_gap got tx %0d then %0d want 1 then 0", gap_tx, post_tx);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_bytes_left got %0d want 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    int bn, dk, dn;
    send_pulse(16'h5A5A, 16'h1234);
    // Byte 4 occupies bit periods 40..49; land in its third data bit.
    repeat (43 * DIV + 1) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({uart_tx, busy, done} !== 3'b100) begin
      errors++;
      $display("FAIL mid_reset got tx/busy/done %b%b%b want 100", uart_tx, busy, done);
    end
    exp_q.delete();
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send_pulse(16'h0BAD, 16'hF00D);
    measure(820, bn, dk, dn);
    check_frame("after_reset", bn, dk, dn);
  endtask

  task automatic test_default_params();
    int low_n;
    int waited;
    low_n = 0;
    waited = 0;
    @(posedge clk);
    #1;
    send2 = 1'b1;
    @(posedge clk);
    #1;
    send2 = 1'b0;
    @(negedge clk);
    checks++;
    if (busy2 !== 1'b1) begin
      errors++;
      $display("FAIL dflt_busy got %b want 1", busy2);
    end
    while (tx2 === 1'b0 && waited < 6000) begin
      low_n++;
      waited++;
      @(negedge clk);
    end
    checks++;
    if (low_n != 5208) begin
      errors++;
      $display("FAIL dflt_bit_period got %0d want 5208", low_n);
    end
    rst2_n = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_checksum();
    test_busy_latch();
    test_back_to_back();
    test_reset_mid_frame();
    test_default_params();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
